// File: rtl/instr_mem_encoder_writer.sv
// Program-load path: encodes field tuples into 16-bit instruction words, buffers them and
// writes them to instruction memory at an auto-incrementing address. `define ENC_RANGE_CHECK_EN to reject illegal tuples.
module instr_mem_encoder_writer #(
    parameter int ADDR_W     = 8,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              field_valid,
    output logic              field_ready,
    input  logic [3:0]        opcode,
    input  logic [3:0]        rs,
    input  logic [3:0]        rt,
    input  logic [3:0]        rd,
    input  logic [7:0]        imm,
    input  logic              last,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   instr_count,
    output logic [7:0]        err_count
);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;
    state_t state, state_nxt;

    logic [15:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, fifo_cnt;
    logic             fifo_full, fifo_empty;
    logic             last_seen;
    logic             is_itype, legal;
    logic             hs, push, pop, wr_done, wrap_now;
    logic [15:0]      enc_word;

    assign is_itype = (opcode >= 4'd5) && (opcode <= 4'd7);
    assign enc_word = {opcode, rs, rt, is_itype ? imm[3:0] : rd};

    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_cnt == PTR_W'(FIFO_DEPTH));
    assign fifo_empty = (wr_ptr == rd_ptr);

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign field_ready = (state == S_ACTIVE) && !fifo_full && !last_seen;

    assign hs       = field_valid && field_ready;
    assign push     = hs && legal;
    assign wr_done  = mem_we && mem_ready;
    // The last address completing ends the session; nothing behind it may be written.
    assign wrap_now = wr_done && (mem_addr == ADDR_MAX);
    assign pop      = (state == S_ACTIVE) && !fifo_empty && (!mem_we || mem_ready);

`ifdef ENC_RANGE_CHECK_EN
    assign legal = (opcode <= 4'd7) && !(is_itype && (imm[7:4] != 4'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (state == S_IDLE) begin
            if (start) err_count <= 8'd0;
        end else if (hs && !legal && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[7:4];
    assign legal         = 1'b1;
    assign err_count     = 8'd0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start) state_nxt = S_ACTIVE;
            S_ACTIVE: if (wrap_now || (last_seen && fifo_empty && !mem_we)) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[IDX_W-1:0]] <= enc_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            last_seen   <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= BASE;
            mem_wdata   <= 16'd0;
            overflow    <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                if (start) begin
                    mem_addr    <= BASE;
                    instr_count <= '0;
                    overflow    <= 1'b0;
                    last_seen   <= 1'b0;
                    wr_ptr      <= '0;
                    rd_ptr      <= '0;
                end
            end else begin
                if (hs && last) last_seen <= 1'b1;
                if (wr_done) begin
                    instr_count <= instr_count + 1'b1;
                    if (!wrap_now) mem_addr <= mem_addr + 1'b1;
                end
                if (wrap_now) begin
                    // Flush: a tuple accepted in this same cycle is dropped as well.
                    overflow <= 1'b1;
                    mem_we   <= 1'b0;
                    rd_ptr   <= wr_ptr;
                end else begin
                    if (push) wr_ptr <= wr_ptr + 1'b1;
                    if (pop) begin
                        rd_ptr    <= rd_ptr + 1'b1;
                        mem_wdata <= fifo_mem[rd_ptr[IDX_W-1:0]];
                        mem_we    <= 1'b1;
                    end else if (wr_done) begin
                        mem_we <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_mem_encoder_writer.sv
// Randomized bench for instr_mem_encoder_writer against a queue-based model of the load path.
module tb_instr_mem_encoder_writer;
    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam logic [AW-1:0] AMAX = '1;
`ifdef ENC_RANGE_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          field_valid = 1'b0;
    logic          field_ready;
    logic [3:0]    opcode = '0, rs = '0, rt = '0, rd = '0;
    logic [7:0]    imm = '0;
    logic          last = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          busy, done, overflow;
    logic [AW:0]   instr_count;
    logic [7:0]    err_count;

    int errors = 0, checks = 0, cyc = 0, ready_pct = 100;

    instr_mem_encoder_writer #(.ADDR_W(AW), .BASE_ADDR(0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .field_valid(field_valid),
        .field_ready(field_ready), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .last(last), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .overflow(overflow),
        .instr_count(instr_count), .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(negedge clk) mem_ready = ($urandom_range(99) < ready_pct);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] encode(input logic [3:0] op, r1, r2, r3, input logic [7:0] im);
        if (op >= 4'd5 && op <= 4'd7) return {op, r1, r2, im[3:0]};
        return {op, r1, r2, r3};
    endfunction

    function automatic bit illegal(input logic [3:0] op, input logic [7:0] im);
        return (op > 4'd7) || (op >= 4'd5 && im[7:4] != 4'd0);
    endfunction

    // Model: words accepted but not yet written (including the one in the write stage).
    logic [15:0]   exp_q[$];
    logic [AW-1:0] log_addr[$];
    logic [15:0]   log_data[$];
    int            log_cyc[$];
    int            phase_m = 0, wr_cnt_m = 0, err_m = 0, m_n, m_f;
    bit            ovf_m = 0, ls_m = 0, we_m = 0, stall_prev = 0;
    bit            m_hs, m_wr, m_wrap, m_ls_nx, m_end;
    logic [15:0]   m_pd, m_w;
    logic [AW-1:0] m_pa, m_exp_addr;

    always @(negedge clk) begin
        #2;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            phase_m = 0; wr_cnt_m = 0; err_m = 0;
            ovf_m = 0; ls_m = 0; we_m = 0; stall_prev = 0;
        end else begin
            m_n = exp_q.size();
            m_f = m_n - (we_m ? 1 : 0);
            chk("busy", busy, phase_m != 0);
            chk("done", done, phase_m == 2);
            chk("field_ready", field_ready, phase_m == 1 && m_f < DEPTH && !ls_m);
            chk("mem_we", mem_we, we_m);
            if (stall_prev) begin
                chk("hold_addr", mem_addr, m_pa);
                chk("hold_wdata", mem_wdata, m_pd);
            end
            if (phase_m == 2) begin
                chk("end_instr_count", instr_count, wr_cnt_m);
                chk("end_overflow", overflow, ovf_m);
                chk("end_err_count", err_count, err_m);
            end
            m_hs    = field_valid && phase_m == 1 && m_f < DEPTH && !ls_m;
            m_ls_nx = ls_m;
            if (m_hs) begin
                if (CHECK_ON && illegal(opcode, imm)) begin
                    if (err_m < 255) err_m++;
                end else begin
                    exp_q.push_back(encode(opcode, rs, rt, rd, imm));
                end
                if (last) m_ls_nx = 1;
            end
            m_wr   = we_m && mem_ready;
            m_wrap = 0;
            if (m_wr) begin
                m_exp_addr = AW'(wr_cnt_m);
                m_w = exp_q.pop_front();
                chk("wr_addr", mem_addr, m_exp_addr);
                chk("wr_data", mem_wdata, m_w);
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_wdata);
                log_cyc.push_back(cyc);
                wr_cnt_m++;
                if (m_exp_addr == AMAX) begin
                    m_wrap = 1; ovf_m = 1; exp_q.delete();
                end
            end
            stall_prev = we_m && !mem_ready;
            m_pa = mem_addr;
            m_pd = mem_wdata;
            m_end = m_wrap || (ls_m && m_n == 0);
            we_m = (we_m && !mem_ready) || (phase_m == 1 && !m_wrap && m_f > 0);
            ls_m = m_ls_nx;
            case (phase_m)
                0: if (start) begin
                       phase_m = 1; wr_cnt_m = 0; err_m = 0; ovf_m = 0; ls_m = 0;
                   end
                1: if (m_end) phase_m = 2;
                default: phase_m = 0;
            endcase
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, r1, r2, r3, input logic [7:0] im, input bit lst);
        int t;
        t = 0;
        opcode = op; rs = r1; rt = r2; rd = r3; imm = im; last = lst;
        field_valid = 1'b1;
        while (busy && !field_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            checks++; errors++;
            $display("FAIL send_timeout: field_ready=0 for %0d cycles, expected acceptance", t);
        end
        if (field_ready) @(negedge clk);
        field_valid = 1'b0;
        last = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 1000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL idle_timeout: busy=%0b, expected 0", busy);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run still active, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int b, len, vp;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_field_ready", field_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_instr_count", instr_count, 0);
        chk("rst_err_count", err_count, 0);
        @(negedge clk);

        // Tuples offered while idle are not taken.
        field_valid = 1'b1; opcode = 4'h3;
        repeat (3) @(negedge clk);
        chk("idle_ready", field_ready, 0);
        field_valid = 1'b0;

        // Single R-type word.
        b = log_data.size();
        pulse_start();
        send(4'd0, 4'd1, 4'd2, 4'd3, 8'h00, 1'b1);
        wait_idle();
        chk("t1_nwr", log_data.size() - b, 1);
        chk("t1_addr", log_addr[b], 0);
        chk("t1_data", log_data[b], 16'h0123);
        chk("t1_count", instr_count, 1);

        // BEQ then LOAD, back to back.
        b = log_data.size();
        pulse_start();
        send(4'd5, 4'd4, 4'd5, 4'd0, 8'h09, 1'b0);
        send(4'd6, 4'd2, 4'd0, 4'd0, 8'h03, 1'b1);
        wait_idle();
        chk("t2_data0", log_data[b], 16'h5459);
        chk("t2_addr1", log_addr[b+1], 1);
        chk("t2_data1", log_data[b+1], 16'h6203);
        chk("t2_b2b", log_cyc[b+1] - log_cyc[b], 1);

        // Memory stalled: 5 tuples taken, the 6th is held off; start mid-session is ignored.
        ready_pct = 0;
        b = log_data.size();
        pulse_start();
        for (int k = 0; k < 5; k++) send(4'd1, 4'(k), 4'(k), 4'(k), 8'h00, 1'b0);
        opcode = 4'd1; rs = 4'd5; rt = 4'd5; rd = 4'd5; field_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("stall_ready", field_ready, 0);
        chk("stall_we", mem_we, 1);
        chk("stall_addr", mem_addr, 0);
        chk("stall_wdata", mem_wdata, 16'h1000);
        ready_pct = 100;
        send(4'd1, 4'd5, 4'd5, 4'd5, 8'h00, 1'b1);
        wait_idle();
        for (int k = 0; k < 6; k++) begin
            chk("t3_addr", log_addr[b+k], k);
            chk("t3_data", log_data[b+k], 16'h1000 + 16'(k * 16'h111));
        end
        chk("t3_count", instr_count, 6);

        // Address space exhaustion.
        b = log_data.size();
        pulse_start();
        for (int k = 0; k < 20; k++) send(4'd2, 4'(k), 4'(k), 4'd0, 8'h00, k == 19);
        wait_idle();
        chk("wrap_nwr", log_data.size() - b, 16);
        chk("wrap_first", log_data[b], 16'h2000);
        chk("wrap_last_addr", log_addr[b+15], 15);
        chk("wrap_overflow", overflow, 1);
        chk("wrap_count", instr_count, 16);

        // Out-of-range opcode and wide immediate.
        b = log_data.size();
        pulse_start();
        send(4'd9, 4'd1, 4'd1, 4'd1, 8'h00, 1'b0);
        send(4'd6, 4'd0, 4'd0, 4'd0, 8'h1F, 1'b1);
        wait_idle();
`ifdef ENC_RANGE_CHECK_EN
        chk("range_nwr", log_data.size() - b, 0);
        chk("range_err", err_count, 2);
`else
        chk("range_data0", log_data[b], 16'h9111);
        chk("range_data1", log_data[b+1], 16'h600F);
        chk("range_err", err_count, 0);
`endif

        // Reset with words buffered.
        ready_pct = 0;
        pulse_start();
        for (int k = 0; k < 4; k++) send(4'd3, 4'(k), 4'd1, 4'd2, 8'h00, 1'b0);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mrst_we", mem_we, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", field_ready, 0);
        chk("mrst_addr", mem_addr, 0);
        chk("mrst_wdata", mem_wdata, 0);
        chk("mrst_count", instr_count, 0);
        chk("mrst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ready_pct = 100;
        b = log_data.size();
        pulse_start();
        send(4'd3, 4'd7, 4'd8, 4'd9, 8'h00, 1'b1);
        wait_idle();
        chk("mrst_nwr", log_data.size() - b, 1);
        chk("mrst_restart_addr", log_addr[b], 0);
        chk("mrst_restart_data", log_data[b], 16'h3789);

        // Random sessions.
        for (int s = 0; s < 25; s++) begin
            len = $urandom_range(20, 1);
            vp  = $urandom_range(100, 40);
            ready_pct = $urandom_range(100, 30);
            pulse_start();
            for (int i = 0; i < len; i++) begin
                while ($urandom_range(99) >= vp) @(negedge clk);
                send(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
                     4'($urandom_range(15)), 8'($urandom_range(255)), i == len - 1);
            end
            wait_idle();
        end

        ready_pct = 100;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
